// File: rtl/async_fifo_rd_sched.sv
// Round-robin read scheduler over N_CH async FIFOs in the rd_clk domain.
// Ports: ch_empty/ch_cnt/ch_rd_data in, ch_rd_en out; m_valid/m_data/m_ch out with m_ready in.
module async_fifo_rd_sched #(
    parameter  int N_CH   = 4,
    parameter  int DEPTH  = 16,
    parameter  int DWIDTH = 64,
    parameter  int BURST  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic                    rd_clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_empty,
    input  logic [N_CH*CNT_W-1:0]   ch_cnt,
    output logic [N_CH-1:0]         ch_rd_en,
    input  logic [N_CH*DWIDTH-1:0]  ch_rd_data,
    output logic                    m_valid,
    output logic [DWIDTH-1:0]       m_data,
    output logic [CH_W-1:0]         m_ch,
    input  logic                    m_ready
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            state, state_n;
    logic [CH_W-1:0]   grant, last_grant, tag, pick;
    logic [CNT_W-1:0]  len, beats, sel_cnt, first_len;
    logic              hit, issue, issue_ok, done, pop, inflight;
    logic [2:0]        pend;
    logic [1:0]        occ;
    logic              wr_ptr, rd_ptr;
    logic [DWIDTH-1:0] skid_d [2];
    logic [CH_W-1:0]   skid_c [2];

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base,
                                               input int k);
        int t;
        t = int'(base) + 1 + k;
        if (t >= N_CH) t = t - N_CH;
        return CH_W'(t);
    endfunction

    // First non-empty channel after the last one served.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!hit && !ch_empty[rr_idx(last_grant, k)]) begin
                hit  = 1'b1;
                pick = rr_idx(last_grant, k);
            end
        end
    end

    // Burst length: min(count, BURST), never zero.
    always_comb begin
        sel_cnt   = ch_cnt[pick*CNT_W +: CNT_W];
        first_len = (sel_cnt < CNT_W'(BURST)) ? sel_cnt : CNT_W'(BURST);
        if (first_len == '0) first_len = CNT_W'(1);
    end

    assign pop  = m_valid & m_ready;
    assign pend = {1'b0, occ} + {2'b0, inflight};

    // Skid holds 2; a read only goes out if its word has a free slot on return.
    assign issue_ok = (pend < 3'd2) || ((pend == 3'd2) && pop);

    always_comb begin
        state_n  = state;
        ch_rd_en = '0;
        issue    = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (hit) state_n = S_BURST;
            end
            S_BURST: begin
                issue           = issue_ok & ~ch_empty[grant] & ~rst;
                ch_rd_en[grant] = issue;
                // A stale count may promise more than exists; empty ends it.
                if ((beats + CNT_W'(issue)) == len || ch_empty[grant]) begin
                    state_n = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= CH_W'(N_CH - 1);
            len        <= '0;
            beats      <= '0;
            inflight   <= 1'b0;
            tag        <= '0;
            occ        <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                skid_d[i] <= '0;
                skid_c[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (state == S_IDLE && hit) begin
                grant <= pick;
                len   <= first_len;
                beats <= '0;
            end
            if (issue) beats <= beats + CNT_W'(1);
            if (done) last_grant <= grant;
            inflight <= issue;
            if (issue) tag <= grant;
            // Read data is valid the cycle after its enable.
            if (inflight) begin
                skid_d[wr_ptr] <= ch_rd_data[tag*DWIDTH +: DWIDTH];
                skid_c[wr_ptr] <= tag;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = skid_d[rd_ptr];
    assign m_ch    = skid_c[rd_ptr];

endmodule

// File: tb/tb_async_fifo_rd_sched.sv
// Directed bench for async_fifo_rd_sched with a behavioural FIFO source per channel.
// Words are tagged {channel, sequence number} so order, loss and duplication are visible.
module tb_async_fifo_rd_sched;

    localparam int N = 4;
    localparam int CW = 5;
    localparam int DW = 64;

    logic            clk;
    logic            rst;
    logic [N-1:0]    ch_empty;
    logic [N*CW-1:0] ch_cnt;
    logic [N-1:0]    ch_rd_en;
    logic [N*DW-1:0] rdata;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_ch;
    logic            m_ready;

    int loaded [N];
    int reads  [N];
    int cnt_ovr[N];
    int base   [N];
    int got    [N];
    logic [3:0] exp_rd [64];
    int nvec = 0;
    int nerr = 0;

    async_fifo_rd_sched dut (
        .rd_clk    (clk),
        .rst       (rst),
        .ch_empty  (ch_empty),
        .ch_cnt    (ch_cnt),
        .ch_rd_en  (ch_rd_en),
        .ch_rd_data(rdata),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word(input int c, input int k);
        return {8'(c), 56'(k)};
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            int av;
            int cv;
            av = loaded[i] - reads[i];
            cv = (cnt_ovr[i] >= 0) ? cnt_ovr[i] : av;
            if (cv > 16) cv = 16;
            if (cv < 0) cv = 0;
            ch_empty[i] = (av <= 0);
            ch_cnt[i*CW +: CW] = CW'(cv);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ch_rd_en[i]) begin
                rdata[i*DW +: DW] <= word(i, reads[i]);
                reads[i] <= reads[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 64; i++) exp_rd[i] = 4'b0;
    endtask

    // With m_ready=1 a read at cycle k appears on the output at k+2.
    task automatic run_table(input int ncyc);
        for (int c = 0; c < N; c++) begin
            base[c] = reads[c];
            got[c]  = 0;
        end
        for (int n = 0; n < ncyc; n++) begin
            logic ev;
            int   ec;
            @(negedge clk);
            check($sformatf("rd_en@%0d", n), 64'(ch_rd_en), 64'(exp_rd[n]));
            ev = (n >= 2) && (exp_rd[n-2] != 4'b0);
            ec = 0;
            if (ev) for (int c = 0; c < N; c++) if (exp_rd[n-2][c]) ec = c;
            check($sformatf("valid@%0d", n), 64'(m_valid), 64'(ev));
            if (ev) begin
                check($sformatf("ch@%0d", n), 64'(m_ch), 64'(ec));
                check($sformatf("data@%0d", n), m_data,
                      word(ec, base[ec] + got[ec]));
                got[ec]++;
            end
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bp_base, bp_got, r0;
        logic stalled;
        logic [63:0] prev_d;
        logic [1:0]  prev_c;

        for (int i = 0; i < N; i++) cnt_ovr[i] = -1;
        rst = 1'b1;
        m_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_rd_en", 64'(ch_rd_en), 64'h0);
        check("rst_valid", 64'(m_valid), 64'h0);
        check("rst_data", m_data, 64'h0);
        check("rst_ch", 64'(m_ch), 64'h0);
        tick();

        // Single channel: ch2 holds 3 words.
        rst = 1'b0;
        loaded[2] = reads[2] + 3;
        clear_tab();
        for (int i = 1; i <= 3; i++) exp_rd[i] = 4'b0100;
        run_table(8);

        // Round robin from a fresh reset: 8 bursts of 4, one idle between.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < N; c++) loaded[c] = reads[c] + 8;
        clear_tab();
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < 4; j++)
                exp_rd[1 + 5*b + j] = 4'(1 << (b % 4));
        run_table(44);

        // Early termination: ch1 claims 4, holds 2; ch2 holds 1.
        loaded[1] = reads[1] + 2;
        cnt_ovr[1] = 4;
        loaded[2] = reads[2] + 1;
        clear_tab();
        exp_rd[1] = 4'b0010;
        exp_rd[2] = 4'b0010;
        exp_rd[5] = 4'b0100;
        run_table(10);
        cnt_ovr[1] = -1;

        // Backpressure: 12 words on ch0, m_ready toggling every 3 cycles.
        bp_base = reads[0];
        bp_got = 0;
        loaded[0] = reads[0] + 12;
        stalled = 1'b0;
        prev_d = '0;
        prev_c = '0;
        for (int cyc = 0; cyc < 200 && bp_got < 12; cyc++) begin
            m_ready = ((cyc / 3) % 2) == 1;
            @(negedge clk);
            check("bp_outstanding",
                  64'((reads[0] - bp_base - bp_got) <= 2), 64'h1);
            check("bp_other_rd", 64'(ch_rd_en[3:1]), 64'h0);
            if (stalled) begin
                check("bp_hold_valid", 64'(m_valid), 64'h1);
                check("bp_hold_data", m_data, prev_d);
                check("bp_hold_ch", 64'(m_ch), 64'(prev_c));
            end
            if (m_valid && m_ready) begin
                check("bp_data", m_data, word(0, bp_base + bp_got));
                check("bp_ch", 64'(m_ch), 64'h0);
                bp_got++;
            end
            stalled = m_valid && !m_ready;
            prev_d = m_data;
            prev_c = m_ch;
            tick();
        end
        check("bp_count", 64'(bp_got), 64'd12);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("bp_drained", 64'(m_valid), 64'h0);
        check("bp_reads", 64'(reads[0] - bp_base), 64'd12);
        tick();

        // Reset mid-burst on ch3 with one word in flight.
        loaded[3] = reads[3] + 4;
        @(negedge clk);
        check("mid_c0_rd", 64'(ch_rd_en), 64'h0);
        tick();
        @(negedge clk);
        check("mid_c1_rd", 64'(ch_rd_en), 64'b1000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0 = reads[0];
        loaded[0] = reads[0] + 1;
        @(negedge clk);
        check("mid_after_rd", 64'(ch_rd_en), 64'h0);
        check("mid_after_valid", 64'(m_valid), 64'h0);
        tick();
        @(negedge clk);
        check("mid_restart_ch0", 64'(ch_rd_en), 64'b0001);
        tick();
        @(negedge clk);
        check("mid_idle", 64'(ch_rd_en), 64'h0);
        tick();
        @(negedge clk);
        check("mid_then_ch3", 64'(ch_rd_en), 64'b1000);
        check("mid_out_valid", 64'(m_valid), 64'h1);
        check("mid_out_ch", 64'(m_ch), 64'h0);
        check("mid_out_data", m_data, word(0, r0));
        for (int i = 0; i < 15; i++) tick();

        // Starvation: ch0 always full, ch3 gets a single word.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        loaded[0] = reads[0] + 100;
        loaded[3] = reads[3] + 1;
        clear_tab();
        for (int i = 1; i <= 4; i++) exp_rd[i] = 4'b0001;
        exp_rd[6] = 4'b1000;
        for (int i = 8; i <= 11; i++) exp_rd[i] = 4'b0001;
        run_table(13);
        loaded[0] = reads[0];
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        check("end_idle_rd", 64'(ch_rd_en), 64'h0);
        check("end_idle_valid", 64'(m_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
